// File: rtl/goertzel_pkg.sv
// goertzel_pkg
//   Shared widths, FSM state encoding and saturation helpers for the single-bin
//   Goertzel tone detector (goertzel_bin_detector) and its multiplier (goertzel_mult).
package goertzel_pkg;

  localparam int SAMP_W     = 8;   // input sample width
  localparam int ST_W       = 24;  // Goertzel state s1/s2 width
  localparam int PWR_W      = 48;  // multiplier product width
  localparam int OUT_W      = 32;  // reported power width
  localparam int COEFF_FRAC = 14;  // fractional bits of the Q2.14 coefficient
  localparam int CNT_W      = 8;   // sample counter width
  // a + b - c can reach about 3 * 2^46, so the power accumulator needs 50 bits.
  localparam int ACC_W      = 50;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StAdd,
    StP1,
    StP2,
    StP3,
    StP4,
    StP5
  } state_e;

  // Clamp a wide signed value into signed ST_W bits.
  function automatic logic signed [ST_W-1:0] sat24(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-ST_W:0] top;
    top = v[ACC_W-1:ST_W-1];
    if (&top || ~|top) begin
      return v[ST_W-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(ST_W-1){1'b0}}};
    end else begin
      return {1'b0, {(ST_W-1){1'b1}}};
    end
  endfunction

  // Clamp a wide signed value into unsigned OUT_W bits (negatives go to 0).
  function automatic logic [OUT_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) begin
      return '0;
    end else if (|v[ACC_W-2:OUT_W]) begin
      return '1;
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/goertzel_mult.sv
// goertzel_mult
//   Combinational signed 24x24 -> 48 multiplier shared by every product the
//   detector needs. Operand selection and result registering live in the caller.
// Ports:
//   op_a, op_b  in   signed ST_W-bit operands
//   prod        out  signed PWR_W-bit product
module goertzel_mult
  import goertzel_pkg::*;
(
  input  logic signed [ST_W-1:0]  op_a,
  input  logic signed [ST_W-1:0]  op_b,
  output logic signed [PWR_W-1:0] prod
);

  assign prod = PWR_W'(op_a) * PWR_W'(op_b);

endmodule

// File: rtl/goertzel_bin_detector.sv
// goertzel_bin_detector
//   Single-bin Goertzel tone detector. Consumes signed 8-bit samples, runs the
//   Goertzel recurrence over N_SAMPLES samples per frame, then reports the bin power
//   and a tone-present flag. One shared multiplier is time-multiplexed by the FSM.
//   Optional build macro GOERTZEL_HYST_EN: detect_out needs two consecutive frames on
//   the same side of THRESHOLD before it changes.
// Ports:
//   clk_in           in   system clock
//   rst_n_in         in   asynchronous active-low reset
//   clear_in         in   synchronous frame abort, drops the partial frame
//   sample_in        in   signed sample
//   sample_valid_in  in   sample strobe, accepted when ready_out is high
//   ready_out        out  high only while idle
//   power_out        out  unsigned bin power of the last completed frame
//   power_valid_out  out  one-cycle pulse when power_out/detect_out update
//   detect_out       out  tone-present flag
//   overrun_out      out  sticky, a sample arrived while ready_out was low
module goertzel_bin_detector
  import goertzel_pkg::*;
#(
  parameter int unsigned      N_SAMPLES = 96,
  parameter int               COEFF     = 30274,
  parameter int unsigned      PWR_SHIFT = 16,
  parameter logic [OUT_W-1:0] THRESHOLD = 32'd4096
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear_in,
  input  logic [SAMP_W-1:0] sample_in,
  input  logic              sample_valid_in,
  output logic              ready_out,
  output logic [OUT_W-1:0]  power_out,
  output logic              power_valid_out,
  output logic              detect_out,
  output logic              overrun_out
);

  localparam logic signed [ST_W-1:0] CoeffExt = ST_W'(COEFF);
  localparam logic [CNT_W-1:0]       NCnt     = CNT_W'(N_SAMPLES);

  state_e                   state_q, state_d;
  logic signed [SAMP_W-1:0] x_q, x_d;
  logic signed [PWR_W-1:0]  prod_q, prod_d, mult_prod;
  logic signed [ST_W-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic signed [ST_W-1:0]   op_a, op_b;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  add_sum, raw_pos;
  logic [OUT_W-1:0]         power_q, power_d, power_next;
  logic                     pvalid_q, pvalid_d;
  logic                     detect_q, detect_d, detect_next;
  logic                     overrun_q, overrun_d;
  logic                     ready, accept, hit;

  goertzel_mult u_mult (
    .op_a (op_a),
    .op_b (op_b),
    .prod (mult_prod)
  );

  assign ready  = (state_q == StIdle);
  assign accept = sample_valid_in & ready & ~clear_in;

  // Recurrence: s0 = x + coeff*s1 - s2, with coeff*s1 already in prod_q.
  assign add_sum = ACC_W'(x_q) + (ACC_W'(prod_q) >>> COEFF_FRAC) - ACC_W'(s2_q);

  // acc_q holds a + b - c after P4.
  assign raw_pos    = acc_q[ACC_W-1] ? '0 : acc_q;
  assign power_next = sat32(raw_pos >>> PWR_SHIFT);
  assign hit        = (power_next >= THRESHOLD);

`ifdef GOERTZEL_HYST_EN
  // hist_q[0] is the previous frame's compare; the flag moves only when the last two
  // frames agree.
  logic [1:0] hist_q, hist_d, hist_next;

  assign hist_next   = {hist_q[0], hit};
  assign detect_next = (hist_next == 2'b11) ? 1'b1 :
                       (hist_next == 2'b00) ? 1'b0 : detect_q;

  always_comb begin
    hist_d = hist_q;
    if (state_q == StP5 && !clear_in) begin
      hist_d = hist_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign detect_next = hit;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    prod_d    = prod_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    power_d   = power_q;
    detect_d  = detect_q;
    pvalid_d  = 1'b0;
    overrun_d = overrun_q | (sample_valid_in & ~ready & ~clear_in);
    op_a      = CoeffExt;
    op_b      = s1_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d     = sample_in;
          state_d = StMul;
        end
      end
      StMul: begin
        prod_d  = mult_prod;
        state_d = StAdd;
      end
      StAdd: begin
        s2_d    = s1_q;
        s1_d    = sat24(add_sum);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_d == NCnt) ? StP1 : StIdle;
      end
      StP1: begin
        op_a    = s1_q;
        op_b    = s1_q;
        acc_d   = ACC_W'(mult_prod);
        state_d = StP2;
      end
      StP2: begin
        op_a    = s2_q;
        op_b    = s2_q;
        acc_d   = acc_q + ACC_W'(mult_prod);
        state_d = StP3;
      end
      StP3: begin
        prod_d  = mult_prod;
        state_d = StP4;
      end
      StP4: begin
        // t = (coeff*s1)>>>14 can be ~2x s1; clamp so it fits the 24-bit operand.
        op_a    = sat24(ACC_W'(prod_q) >>> COEFF_FRAC);
        op_b    = s2_q;
        acc_d   = acc_q - ACC_W'(mult_prod);
        state_d = StP5;
      end
      StP5: begin
        power_d  = power_next;
        detect_d = detect_next;
        pvalid_d = 1'b1;
        s1_d     = '0;
        s2_d     = '0;
        cnt_d    = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything, including the P5 report.
    if (clear_in) begin
      state_d  = StIdle;
      s1_d     = '0;
      s2_d     = '0;
      cnt_d    = '0;
      pvalid_d = 1'b0;
      power_d  = power_q;
      detect_d = detect_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      x_q       <= '0;
      prod_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      power_q   <= '0;
      pvalid_q  <= 1'b0;
      detect_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      prod_q    <= prod_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      power_q   <= power_d;
      pvalid_q  <= pvalid_d;
      detect_q  <= detect_d;
      overrun_q <= overrun_d;
    end
  end

  assign ready_out       = ready;
  assign power_out       = power_q;
  assign power_valid_out = pvalid_q;
  assign detect_out      = detect_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_goertzel_bin_detector.sv
// tb_goertzel_bin_detector
//   Scoreboard bench for goertzel_bin_detector. Stimulus pushes the expected report of
//   every completed frame; a monitor pops and compares on each power_valid_out pulse.
//   PWR_SHIFT is lowered to 4 so that small test tones land on both sides of THRESHOLD.
module tb_goertzel_bin_detector;

  localparam int unsigned NS     = 96;
  localparam int unsigned Shift  = 4;
  localparam longint      CoeffL = 30274;
  localparam longint      Thresh = 4096;
  localparam longint      SMax   = 8388607;
  localparam longint      SMin   = -8388608;
  localparam longint      PMax   = 64'd4294967295;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  sample = 8'd0;
  logic        ready;
  logic [31:0] power;
  logic        pvalid;
  logic        detect;
  logic        overrun;

  goertzel_bin_detector #(
    .N_SAMPLES (NS),
    .COEFF     (30274),
    .PWR_SHIFT (Shift),
    .THRESHOLD (32'd4096)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .clear_in        (clear),
    .sample_in       (sample),
    .sample_valid_in (valid),
    .ready_out       (ready),
    .power_out       (power),
    .power_valid_out (pvalid),
    .detect_out      (detect),
    .overrun_out     (overrun)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint power;
    bit     detect;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  bit     det_log[$];
  int     frame_q[$];
  bit     det_m = 1'b0;
  longint last_pwr = 0;
  int     frames_pushed = 0;
  int     valids_seen = 0;
  int     n_checks = 0;
  int     n_fail = 0;
`ifdef GOERTZEL_HYST_EN
  bit     prev_hit = 1'b0;
`endif

  int sine16[16] = '{0, 3, 6, 7, 8, 7, 6, 3, 0, -3, -6, -7, -8, -7, -6, -3};
  int sine8[8]   = '{0, 6, 8, 6, 0, -6, -8, -6};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Direct Goertzel over the buffered frame using plain 64-bit arithmetic.
  function automatic longint model_power();
    longint s1 = 0;
    longint s2 = 0;
    longint s0, t, raw;
    foreach (frame_q[i]) begin
      s0 = clamp(longint'(frame_q[i]) + ((CoeffL * s1) >>> 14) - s2, SMin, SMax);
      s2 = s1;
      s1 = s0;
    end
    t   = (CoeffL * s1) >>> 14;
    raw = s1 * s1 + s2 * s2 - t * s2;
    if (raw < 0) raw = 0;
    return clamp(raw >>> Shift, 0, PMax);
  endfunction

  task automatic finish_frame();
    exp_t   e;
    longint p;
    bit     h;
    p = model_power();
    h = (p >= Thresh);
`ifdef GOERTZEL_HYST_EN
    if (h && prev_hit) det_m = 1'b1;
    else if (!h && !prev_hit) det_m = 1'b0;
    prev_hit = h;
`else
    det_m = h;
`endif
    e.power  = p;
    e.detect = det_m;
    e.cyc    = cyc + 7;
    exp_q.push_back(e);
    frames_pushed++;
    last_pwr = p;
    frame_q.delete();
  endtask

  // Returns #1 after the accepting edge with valid already dropped.
  task automatic send(input int s);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready_out=%0b, expected 1", ready);
      return;
    end
    valid  = 1'b1;
    sample = 8'(s);
    @(posedge clk);
    #1;
    valid = 1'b0;
    frame_q.push_back(s);
    if (frame_q.size() == NS) finish_frame();
  endtask

  // kind: 0 zero, 1 750 Hz, 2 1500 Hz, 3 random full scale with random gaps
  task automatic send_tone(input int kind, input int count);
    for (int i = 0; i < count; i++) begin
      case (kind)
        1:       send(sine16[i % 16]);
        2:       send(sine8[i % 8]);
        3: begin
          send(int'($urandom_range(0, 255)) - 128);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        default: send(0);
      endcase
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    frame_q.delete();
    det_m    = 1'b0;
    last_pwr = 0;
`ifdef GOERTZEL_HYST_EN
    prev_hit = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_power", power, 0);
    check("rst_valid", pvalid, 0);
    check("rst_detect", detect, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && pvalid) begin
      exp_t e;
      valids_seen++;
      det_log.push_back(detect);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got power_valid_out=1, expected 0");
      end else begin
        e = exp_q.pop_front();
        check("power", power, e.power);
        check("detect", detect, e.detect);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    bit exp6[4];

    do_reset();

    // Zero frame, with ready timing around a non-final sample
    send(0);
    @(negedge clk); check("ready_mul", ready, 0);
    @(negedge clk); check("ready_add", ready, 0);
    @(negedge clk); check("ready_back", ready, 1);
    send_tone(0, NS - 1);
    wait_drain();
    check("zero_power", power, 0);

    // In-bin tone
    send_tone(1, NS);
    wait_drain();
    check("t750_above", power >= 32'd4096, 1);

    // Off-bin tone
    send_tone(2, NS);
    wait_drain();
    check("t1500_below", power < 32'd4096, 1);

    // Overrun: strobe while busy, then finish the frame
    check("ovr_before", overrun, 0);
    for (int i = 0; i < NS; i++) begin
      send(sine16[i % 16]);
      if (i == 10) begin
        @(negedge clk);
        valid  = 1'b1;
        sample = 8'h55;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        check("ovr_set", overrun, 1);
      end
    end
    wait_drain();
    check("ovr_sticky", overrun, 1);

    // Random frames
    send_tone(3, 3 * NS);
    wait_drain();

    // Reset mid-frame, then one clean frame
    send_tone(1, 50);
    v0 = valids_seen;
    do_reset();
    send_tone(1, NS);
    wait_drain();
    check("rst_one_valid", valids_seen - v0, 1);

    // Clear mid-frame with a coincident strobe
    send_tone(1, 50);
    v0 = valids_seen;
    @(negedge clk);
    clear  = 1'b1;
    valid  = 1'b1;
    sample = 8'h7f;
    @(posedge clk);
    #1;
    clear = 1'b0;
    valid = 1'b0;
    frame_q.delete();
    @(negedge clk);
    check("clr_ready", ready, 1);
    check("clr_overrun", overrun, 0);
    check("clr_power_hold", power, last_pwr);
    check("clr_detect_hold", detect, det_m);
    send_tone(1, NS);
    wait_drain();
    check("clr_one_valid", valids_seen - v0, 1);

    // Above, below, above, above
    do_reset();
    det_log.delete();
    send_tone(1, NS);
    send_tone(2, NS);
    send_tone(1, NS);
    send_tone(1, NS);
    wait_drain();
`ifdef GOERTZEL_HYST_EN
    exp6 = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp6 = '{1'b1, 1'b0, 1'b1, 1'b1};
`endif
    check("seq_len", det_log.size(), 4);
    if (det_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("seq_detect", det_log[i], exp6[i]);
    end

    check("frame_count", valids_seen, frames_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
